// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared types and defaults for the unified instruction/data
//               memory port arbiter.
// Contents    : resp_owner_e  - which port owns the read response in flight
//               C_*_DEF       - default address/data widths
//               streak_width  - counter width able to hold 0..max
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int C_ADDR_W_DEF = 7;
    localparam int C_DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } resp_owner_e;

    // A zero-width counter is illegal, so a max of 0 still gets one bit.
    function automatic int streak_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_streak_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_streak_counter
// Description : Saturating counter of consecutive data-port wins while the
//               fetch port is waiting.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset
//               inc_i  - count one more data win (saturates at MAX)
//               clr_i  - clear the streak (has priority over inc_i)
//               sat_o  - streak has reached MAX
// Revision    : 1.0 - initial release
// ============================================================================
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int            CW    = streak_width(MAX);
    localparam logic [CW-1:0] C_MAX = CW'(MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat_o = (cnt_q == C_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous RAM (registered address,
//               1-cycle read latency) between the instruction-fetch port (IF)
//               and the CPU data port (D). D has priority, but after
//               MAX_STREAK consecutive D wins against a waiting fetch the
//               fetch is served once. MAX_STREAK = 0 gives strict D priority.
// Ports       : clk, rst                   - clock, async active-high reset
//               if_req/if_addr/if_gnt      - fetch request and grant
//               if_rvalid/if_rdata         - fetch read response
//               d_req/d_we/d_addr/d_wdata  - data request
//               d_gnt                      - data grant
//               d_rvalid/d_rdata           - data read response
//               mem_addr/mem_wren/mem_data - RAM command
//               mem_q                      - RAM read data (cycle after addr)
//               if_stall                   - fetch waiting this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W_DEF,
    parameter int DATA_W     = C_DATA_W_DEF,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              if_stall
);

    localparam bit C_FAIR_EN = (MAX_STREAK != 0);

    logic        streak_sat;
    logic        fair;
    resp_owner_e owner_q;
    resp_owner_e owner_d;
    logic [DATA_W-1:0] if_hold_q;
    logic [DATA_W-1:0] d_hold_q;

    // ---------------------------------------------------------------- grant
    assign fair     = C_FAIR_EN && streak_sat;
    assign d_gnt    = d_req & ~(if_req & fair);
    assign if_gnt   = if_req & ~d_gnt;
    assign if_stall = if_req & ~if_gnt;

    // ------------------------------------------------------------ RAM mux
    // Write data is passed straight through; it only matters when D writes.
    assign mem_addr = d_gnt ? d_addr : if_addr;
    assign mem_wren = d_gnt & d_we;
    assign mem_data = d_wdata;

    // ------------------------------------------------------------- streak
    // Only D wins against a waiting fetch build the streak; a fetch grant or
    // an idle fetch port ends it.
    arb_streak_counter #(
        .MAX   (MAX_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc_i (d_gnt & if_req),
        .clr_i (if_gnt | ~if_req),
        .sat_o (streak_sat)
    );

    // --------------------------------------------------- response owner
    // Writes complete at grant, so only reads claim the next-cycle response.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == OWN_IF) begin
                if_hold_q <= mem_q;
            end
            if (owner_q == OWN_D) begin
                d_hold_q <= mem_q;
            end
        end
    end

    // Each port shows live RAM data on its response cycle and otherwise
    // keeps presenting the last word it was given.
    assign if_rvalid = (owner_q == OWN_IF);
    assign d_rvalid  = (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_q : if_hold_q;
    assign d_rdata   = d_rvalid  ? mem_q : d_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed vector
//               table, starvation/fairness, hold, reset and withdrawal
//               sequences, then random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_q;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_wren, if_stall;
    logic [DW-1:0] if_rdata, d_rdata, mem_data;
    logic [AW-1:0] mem_addr;

    logic          u0_if_gnt, u0_if_rvalid, u0_d_gnt, u0_d_rvalid;
    logic          u0_mem_wren, u0_if_stall;
    logic [DW-1:0] u0_if_rdata, u0_d_rdata, u0_mem_data;
    logic [AW-1:0] u0_mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
        .mem_q(mem_q), .if_stall(if_stall)
    );

    // Strict-priority variant, observed only for grant behaviour.
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(u0_if_gnt),
        .if_rvalid(u0_if_rvalid), .if_rdata(u0_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(u0_d_gnt), .d_rvalid(u0_d_rvalid), .d_rdata(u0_d_rdata),
        .mem_addr(u0_mem_addr), .mem_wren(u0_mem_wren), .mem_data(u0_mem_data),
        .mem_q(mem_q), .if_stall(u0_if_stall)
    );

    // RAM: registered address, returns pre-write contents of the addressed word.
    logic [DW-1:0] ram [0:127];
    initial begin
        logic [DW-1:0] q_tmp;
        for (int i = 0; i < 128; i++) ram[i] = 32'h100 + i;
        ram[7] = 32'h77;
        forever begin
            @(posedge clk);
            q_tmp = ram[mem_addr];
            if (mem_wren) ram[mem_addr] = mem_data;
            mem_q <= q_tmp;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ checking
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    // Behavioural view: memory contents, the one expected response per port,
    // the last word each port was given, and how many D wins a waiting fetch
    // has already sat through.
    int            m_waits;
    bit            m_pif, m_pd;
    logic [DW-1:0] m_pif_dat, m_pd_dat, m_hif, m_hd;
    logic [DW-1:0] m_mem [0:127];
    bit            g_if, g_d;

    task automatic model_reset();
        m_waits = 0; m_pif = 0; m_pd = 0;
        m_pif_dat = '0; m_pd_dat = '0; m_hif = '0; m_hd = '0;
    endtask

    task automatic eval();
        bit            fetch_due, eg_d, eg_if;
        logic [AW-1:0] ea;
        fetch_due = (MS != 0) && (m_waits >= MS);
        eg_d  = d_req && !(if_req && fetch_due);
        eg_if = if_req && !eg_d;
        ea    = eg_d ? d_addr : if_addr;
        chk("if_gnt",    if_gnt,    eg_if);
        chk("d_gnt",     d_gnt,     eg_d);
        chk("if_stall",  if_stall,  if_req && !eg_if);
        chk("mem_addr",  mem_addr,  ea);
        chk("mem_wren",  mem_wren,  eg_d && d_we);
        if (eg_d && d_we) chk("mem_data", mem_data, d_wdata);
        chk("if_rvalid", if_rvalid, m_pif);
        chk("d_rvalid",  d_rvalid,  m_pd);
        chk("if_rdata",  if_rdata,  m_pif ? m_pif_dat : m_hif);
        chk("d_rdata",   d_rdata,   m_pd  ? m_pd_dat  : m_hd);
        if (m_pif) m_hif = m_pif_dat;
        if (m_pd)  m_hd  = m_pd_dat;
        m_pif = eg_if;        m_pif_dat = m_mem[if_addr];
        m_pd  = eg_d && !d_we; m_pd_dat = m_mem[d_addr];
        if (eg_d && d_we) m_mem[d_addr] = d_wdata;
        if (eg_if || !if_req) m_waits = 0;
        else if (eg_d)        m_waits = (m_waits < MS) ? m_waits + 1 : MS;
        g_if = eg_if;
        g_d  = eg_d;
    endtask

    task automatic tick();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit dr,
                         input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] wd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
    endtask

    // -------------------------------------------------------- vector table
    typedef struct {
        bit            ir;  logic [AW-1:0] ia;
        bit            dr;  bit dw; logic [AW-1:0] da; logic [DW-1:0] wd;
        bit            eig; bit edg; bit ew; bit es;
        bit            eirv; logic [DW-1:0] eird;
        bit            edrv; logic [DW-1:0] edrd;
    } vec_t;

    function automatic vec_t mkv(bit ir, logic [AW-1:0] ia, bit dr, bit dw,
                                 logic [AW-1:0] da, logic [DW-1:0] wd,
                                 bit eig, bit edg, bit ew, bit es,
                                 bit eirv, logic [DW-1:0] eird,
                                 bit edrv, logic [DW-1:0] edrd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
        v.eig = eig; v.edg = edg; v.ew = ew; v.es = es;
        v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
        return v;
    endfunction

    vec_t tv [12];

    initial begin
        bit pi, pd;

        //          ir ia  dr dw da wdata         ig dg w  s  irv ird        drv drd
        tv[0]  = mkv(1, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 32'h0,      0, 32'h0);
        tv[1]  = mkv(1, 1, 0, 0, 0, 0,            1, 0, 0, 0, 1, 32'h100,    0, 32'h0);
        tv[2]  = mkv(1, 2, 0, 0, 0, 0,            1, 0, 0, 0, 1, 32'h101,    0, 32'h0);
        tv[3]  = mkv(1, 3, 1, 1, 5, 32'hDEADBEEF, 0, 1, 1, 1, 1, 32'h102,    0, 32'h0);
        tv[4]  = mkv(1, 3, 0, 0, 0, 0,            1, 0, 0, 0, 0, 32'h102,    0, 32'h0);
        tv[5]  = mkv(0, 0, 1, 0, 5, 0,            0, 1, 0, 0, 1, 32'h103,    0, 32'h0);
        tv[6]  = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 32'h103,    1, 32'hDEADBEEF);
        tv[7]  = mkv(0, 0, 1, 0, 7, 0,            0, 1, 0, 0, 0, 32'h103,    0, 32'hDEADBEEF);
        tv[8]  = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 32'h103,    1, 32'h77);
        tv[9]  = mkv(1, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 32'h103,    0, 32'h77);
        tv[10] = mkv(1, 1, 0, 0, 0, 0,            1, 0, 0, 0, 1, 32'h100,    0, 32'h77);
        tv[11] = mkv(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 32'h101,    0, 32'h77);

        for (int i = 0; i < 128; i++) m_mem[i] = 32'h100 + i;
        m_mem[7] = 32'h77;
        g_if = 0; g_d = 0;

        // ---- reset state
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst if_rvalid", if_rvalid, 1'b0);
        chk("rst d_rvalid",  d_rvalid,  1'b0);
        chk("rst if_rdata",  if_rdata,  32'h0);
        chk("rst d_rdata",   d_rdata,   32'h0);
        chk("rst mem_wren",  mem_wren,  1'b0);
        rst = 1'b0;

        // ---- directed table: IF burst, write vs fetch, RAW, hold
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].wd);
            @(negedge clk);
            chk($sformatf("vec%0d if_gnt", i),    if_gnt,    tv[i].eig);
            chk($sformatf("vec%0d d_gnt", i),     d_gnt,     tv[i].edg);
            chk($sformatf("vec%0d mem_wren", i),  mem_wren,  tv[i].ew);
            chk($sformatf("vec%0d if_stall", i),  if_stall,  tv[i].es);
            chk($sformatf("vec%0d if_rvalid", i), if_rvalid, tv[i].eirv);
            chk($sformatf("vec%0d if_rdata", i),  if_rdata,  tv[i].eird);
            chk($sformatf("vec%0d d_rvalid", i),  d_rvalid,  tv[i].edrv);
            chk($sformatf("vec%0d d_rdata", i),   d_rdata,   tv[i].edrd);
            eval();
            @(posedge clk);
            #1;
        end

        // ---- starvation: both requesting for 10 cycles
        for (int i = 0; i < 10; i++) begin
            drive(1, 20, 1, 0, 10, 0);
            @(negedge clk);
            chk($sformatf("starve%0d d_gnt", i),    d_gnt,    (i % 5) != 4);
            chk($sformatf("starve%0d if_gnt", i),   if_gnt,   (i % 5) == 4);
            chk($sformatf("starve%0d if_stall", i), if_stall, (i % 5) != 4);
            chk($sformatf("strict%0d d_gnt", i),    u0_d_gnt,  1'b1);
            chk($sformatf("strict%0d if_gnt", i),   u0_if_gnt, 1'b0);
            eval();
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // ---- withdrawn D write while fetch is due
        for (int i = 0; i < 4; i++) begin
            drive(1, 4, 1, 0, 10, 0);
            tick();
        end
        drive(1, 4, 1, 1, 9, 32'h00000BAD);
        @(negedge clk);
        chk("wd d_gnt",    d_gnt,    1'b0);
        chk("wd if_gnt",   if_gnt,   1'b1);
        chk("wd mem_wren", mem_wren, 1'b0);
        eval();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wd if_rdata", if_rdata, 32'h104);
        eval();
        @(posedge clk);
        #1;
        drive(0, 0, 1, 0, 9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wd mem9", d_rdata, 32'h109);
        eval();
        @(posedge clk);
        #1;

        // ---- reset while a fetch read is in flight
        drive(1, 2, 0, 0, 0, 0);
        @(negedge clk);
        eval();
        #2;
        rst = 1'b1;
        if_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rstmid if_rvalid", if_rvalid, 1'b0);
        chk("rstmid if_rdata",  if_rdata,  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 30, 1, 0, 31, 0);
            @(negedge clk);
            chk($sformatf("rststreak%0d if_gnt", i), if_gnt, i == 4);
            eval();
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // ---- random traffic against the model
        pi = 0; pd = 0;
        for (int n = 0; n < 600; n++) begin
            if (pi && $urandom_range(0, 19) == 0) pi = 0;
            if (pd && $urandom_range(0, 19) == 0) pd = 0;
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi = 1;
                if_addr = AW'($urandom_range(0, 127));
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1;
                d_we    = ($urandom_range(0, 1) == 1);
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if_req = pi;
            d_req  = pd;
            tick();
            if (g_if) pi = 0;
            if (g_d)  pd = 0;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous single-port RAM between two requesters: the instruction-fetch port (IF) and the CPU data port (D).
- The RAM has a registered address, so read data appears one cycle after the address.
- Sits between the cpu/instruction_queue fetch path and a unified instr/data memory, replacing separate instruction and data RAMs.
- Fixed priority for D, with a bounded-streak rule so fetch is never starved.

Parameters:
ADDR_W, 7, RAM word-address width
DATA_W, 32, RAM data width
MAX_STREAK, 4, max consecutive D grants while IF waits; 0 = strict D priority, no fairness

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  fetch read data valid (one cycle after grant)
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  data read data valid (one cycle after read grant)
d_rdata  out  DATA_W  data read data
mem_addr  out  ADDR_W  RAM address (combinational mux)
mem_wren  out  1  RAM write enable
mem_data  out  DATA_W  RAM write data
mem_q  in  DATA_W  RAM read data, valid the cycle after the address
if_stall  out  1  if_req & ~if_gnt, for the pipeline stall logic

Behaviour:
- Grant rule, one grant max per cycle:
  - fair = (MAX_STREAK != 0) & (streak == MAX_STREAK).
  - d_gnt = d_req & ~(if_req & fair).
  - if_gnt = if_req & ~d_gnt.
- Memory mux:
  - d_gnt: mem_addr = d_addr, mem_wren = d_we, mem_data = d_wdata.
  - otherwise: mem_addr = if_addr, mem_wren = 0, mem_data = d_wdata (don't-care).
  - mem_wren is never 1 without d_gnt.
- Streak counter, width clog2(MAX_STREAK+1):
  - Increments when d_gnt & if_req.
  - Clears to 0 when if_gnt or ~if_req.
  - Otherwise holds.
  - Saturates at MAX_STREAK.
- Response owner register (enum NONE/IF/D), next state:
  - IF if if_gnt.
  - D if d_gnt & ~d_we.
  - else NONE.
  - Writes produce no response; a write is complete at its grant cycle.
- Read latency is exactly 1 cycle:
  - owner==IF -> if_rvalid = 1, if_rdata = mem_q.
  - owner==D -> d_rvalid = 1, d_rdata = mem_q.
- Hold registers:
  - When a port's rvalid is 1, its hold register captures mem_q.
  - When rvalid is 0, that port's rdata outputs its hold register (last delivered word).
- Back-to-back: a new grant may occur in the same cycle as the previous response. Full throughput is 1 access/cycle.
- Simultaneous requests:
  - D wins unless fair=1.
  - With fair=1, IF wins and the streak clears.
- Write-then-read of the same address by D in consecutive grants returns the new data (RAM is read-after-write ordered by cycle).
- Request withdrawn before grant: allowed; no side effects.
- Reset, asynchronous:
  - streak = 0, owner = NONE, hold registers = 0.
  - if_rvalid = d_rvalid = 0, if_rdata = d_rdata = 0.
  - Combinational outputs follow the inputs.
  - A read in flight when rst asserts is dropped: no rvalid after release.
- Reset values of combinational outputs during rst:
  - if_gnt, d_gnt and mem_wren follow the request inputs.
  - The cpu holds requests low during reset.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} resp_owner_e
  - localparams for default ADDR_W/DATA_W.
- One natural sub-module: arb_streak_counter (saturating counter, inc/clr/sat output, parameter MAX).
- Grant, mux and response logic stay in the top module.

Test Plan:
- IF only, addrs 0,1,2 back-to-back; RAM preloaded mem[n]=0x100+n -> if_gnt each cycle; if_rvalid on the following cycles with 0x100, 0x101, 0x102; d_rvalid stays 0.
- D write addr 5 = 0xDEADBEEF with simultaneous IF req addr 3 -> d_gnt=1, if_gnt=0, mem_wren=1, if_stall=1. Next cycle if_gnt=1. Then D read addr 5 returns d_rdata=0xDEADBEEF with d_rvalid one cycle after grant.
- Starvation, MAX_STREAK=4: d_req and if_req held high 10 cycles -> grant pattern D,D,D,D,IF repeating; if_stall high exactly in D cycles. With MAX_STREAK=0: all 10 grants to D.
- Hold: D read addr 7 (=0x77) then d_req low for 3 cycles -> d_rvalid one pulse; d_rdata stays 0x77 while IF reads change mem_q.
- Reset mid-read: IF granted addr 2, rst asserted before the next edge -> if_rvalid never asserts, if_rdata=0, streak=0 after release.
- Withdrawn request: d_req pulsed 1 cycle while fair=1 forces IF win -> no D write occurs (mem unchanged); IF read completes normally.
